// File: rtl/dc_ram_sync2ff_if.sv
`default_nettype none
// ============================================================================
// Module   : dc_ram_sync2ff_if
// Purpose  : Bundles the two RAM ports and the synchronizer channels of the
//            debug mailbox core into one connection.
// Signals  : addr_a/din_a/wr_en_a/dout_a  - port A (debug host side)
//            addr_b/din_b/wr_en_b/dout_b  - port B (CPU/controller side)
//            sync_din/sync_dout           - asynchronous inputs / synchronized
//                                           outputs (bit 0 req, bit 1 ack)
// Modports : master drives addresses, data, enables and sync inputs;
//            slave (the mailbox core) drives read data and sync outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface dc_ram_sync2ff_if #(
  parameter int addr_bits  = 2,
  parameter int data_bits  = 32,
  parameter int sync_width = 2
);
  logic [addr_bits-1:0]  addr_a;
  logic [data_bits-1:0]  din_a;
  logic                  wr_en_a;
  logic [data_bits-1:0]  dout_a;

  logic [addr_bits-1:0]  addr_b;
  logic [data_bits-1:0]  din_b;
  logic                  wr_en_b;
  logic [data_bits-1:0]  dout_b;

  logic [sync_width-1:0] sync_din;
  logic [sync_width-1:0] sync_dout;

  modport master (
    output addr_a, din_a, wr_en_a,
    output addr_b, din_b, wr_en_b,
    output sync_din,
    input  dout_a, dout_b, sync_dout
  );

  modport slave (
    input  addr_a, din_a, wr_en_a,
    input  addr_b, din_b, wr_en_b,
    input  sync_din,
    output dout_a, dout_b, sync_dout
  );
endinterface
`default_nettype wire

// File: rtl/dc_ram_sync2ff.sv
`default_nettype none
// ============================================================================
// Module   : dc_ram_sync2ff
// Purpose  : Debug mailbox core. A small true dual-port RAM with registered,
//            read-first outputs plus a bank of two-flop synchronizers that
//            carry the host request and controller acknowledge bits.
// Ports    : clk   - sole clock, rising edge
//            rst_n - asynchronous active-low reset; clears RAM, read data and
//                    every synchronizer stage
//            bus   - dc_ram_sync2ff_if.slave (both RAM ports, sync channels)
// Revision : 1.0 - initial release
// ============================================================================
module dc_ram_sync2ff #(
  parameter int addr_bits  = 2,
  parameter int data_bits  = 32,
  parameter int sync_width = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  dc_ram_sync2ff_if.slave bus
);

  localparam int depth = 2 ** addr_bits;

  logic [data_bits-1:0]  mem [depth];
  logic [data_bits-1:0]  dout_a_q;
  logic [data_bits-1:0]  dout_b_q;
  logic [sync_width-1:0] stage1;
  logic [sync_width-1:0] stage2;

  // --------------------------------------------------------------------------
  // Storage. Each word has its own write mux so the whole array can be
  // cleared by the asynchronous reset. Port A is checked first, which makes
  // it the winner when both ports write the same word in one cycle.
  // --------------------------------------------------------------------------
  for (genvar w = 0; w < depth; w++) begin : g_word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[w] <= '0;
      end else if (bus.wr_en_a && (bus.addr_a == addr_bits'(w))) begin
        mem[w] <= bus.din_a;
      end else if (bus.wr_en_b && (bus.addr_b == addr_bits'(w))) begin
        mem[w] <= bus.din_b;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered reads. Sampling mem[] before the write lands gives read-first
  // behaviour on the same port and old-data behaviour across ports.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      dout_a_q <= mem[bus.addr_a];
      dout_b_q <= mem[bus.addr_b];
    end
  end

  // --------------------------------------------------------------------------
  // Two-flop synchronizers, one independent chain per bit. No pulse
  // stretching: inputs narrower than a clock period may be missed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= bus.sync_din;
      stage2 <= stage1;
    end
  end

  assign bus.dout_a    = dout_a_q;
  assign bus.dout_b    = dout_b_q;
  assign bus.sync_dout = stage2;

endmodule
`default_nettype wire

// File: tb/tb_dc_ram_sync2ff.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_ram_sync2ff
// Purpose  : Directed self-checking bench for the dc_ram_sync2ff mailbox core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_ram_sync2ff;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dc_ram_sync2ff_if #(.addr_bits(2), .data_bits(32), .sync_width(2)) bus ();

  dc_ram_sync2ff #(
    .addr_bits (2),
    .data_bits (32),
    .sync_width(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.addr_a  = '0;
    bus.din_a   = '0;
    bus.wr_en_a = 1'b0;
    bus.addr_b  = '0;
    bus.din_b   = '0;
    bus.wr_en_b = 1'b0;
    bus.sync_din = '0;

    // Reset state
    tick(); tick();
    check("rst_dout_a", bus.dout_a, 32'h0);
    check("rst_dout_b", bus.dout_b, 32'h0);
    check("rst_sync",   32'(bus.sync_dout), 32'h0);
    rst_n = 1'b1;
    tick();

    // Port A write, port B read
    bus.addr_a = 2'd2; bus.din_a = 32'hDEADBEEF; bus.wr_en_a = 1'b1;
    tick();
    bus.wr_en_a = 1'b0; bus.addr_b = 2'd2;
    tick();
    check("a_wr_b_rd", bus.dout_b, 32'hDEADBEEF);

    // Port B write, port A read
    bus.addr_b = 2'd3; bus.din_b = 32'h12345678; bus.wr_en_b = 1'b1;
    tick();
    bus.wr_en_b = 1'b0; bus.addr_a = 2'd3;
    tick();
    check("b_wr_a_rd", bus.dout_a, 32'h12345678);

    // Read-first, same port and cross port
    bus.addr_a = 2'd1; bus.din_a = 32'h11111111; bus.wr_en_a = 1'b1;
    tick();
    bus.din_a = 32'h22222222; bus.addr_b = 2'd1;
    tick();
    check("rf_cross_old", bus.dout_b, 32'h11111111);
    check("rf_same_old",  bus.dout_a, 32'h11111111);
    bus.wr_en_a = 1'b0;
    tick();
    check("rf_cross_new", bus.dout_b, 32'h22222222);
    check("rf_same_new",  bus.dout_a, 32'h22222222);

    // Collision: A wins
    bus.addr_a = 2'd0; bus.din_a = 32'hAAAA0000; bus.wr_en_a = 1'b1;
    bus.addr_b = 2'd0; bus.din_b = 32'hBBBB0000; bus.wr_en_b = 1'b1;
    tick();
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    tick();
    check("coll_a", bus.dout_a, 32'hAAAA0000);
    check("coll_b", bus.dout_b, 32'hAAAA0000);

    // Simultaneous writes to different addresses
    bus.addr_a = 2'd2; bus.din_a = 32'h00000001; bus.wr_en_a = 1'b1;
    bus.addr_b = 2'd3; bus.din_b = 32'h00000002; bus.wr_en_b = 1'b1;
    tick();
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    bus.addr_a = 2'd3; bus.addr_b = 2'd2;
    tick();
    check("dual_wr_a", bus.dout_a, 32'h00000002);
    check("dual_wr_b", bus.dout_b, 32'h00000001);

    // Synchronizer latency on channel 0, channel 1 stays low
    bus.sync_din = 2'b01;
    tick();
    check("sync_rise_n1", 32'(bus.sync_dout), 32'h0);
    tick();
    check("sync_rise_n2", 32'(bus.sync_dout), 32'h1);
    bus.sync_din = 2'b00;
    tick();
    check("sync_fall_n1", 32'(bus.sync_dout), 32'h1);
    tick();
    check("sync_fall_n2", 32'(bus.sync_dout), 32'h0);

    // Request / acknowledge loop
    bus.sync_din = 2'b01;
    waited = 0;
    while (bus.sync_dout[0] !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check("req_seen", 32'(bus.sync_dout[0]), 32'h1);
    check("req_latency", 32'(waited), 32'd2);
    bus.sync_din = 2'b11;
    tick();
    check("ack_n1", 32'(bus.sync_dout), 32'h1);
    tick();
    check("ack_n2", 32'(bus.sync_dout), 32'h3);
    bus.sync_din = 2'b00;
    tick();
    check("drop_n1", 32'(bus.sync_dout), 32'h3);
    tick();
    check("drop_n2", 32'(bus.sync_dout), 32'h0);

    // Mid-run asynchronous reset with nonzero memory and outputs
    bus.addr_a = 2'd2; bus.addr_b = 2'd3; bus.sync_din = 2'b11;
    tick(); tick(); tick();
    check("pre_rst_a",    bus.dout_a, 32'h00000001);
    check("pre_rst_b",    bus.dout_b, 32'h00000002);
    check("pre_rst_sync", 32'(bus.sync_dout), 32'h3);
    bus.addr_a = 2'd1; bus.din_a = 32'hCAFEF00D; bus.wr_en_a = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout_a", bus.dout_a, 32'h0);
    check("arst_dout_b", bus.dout_b, 32'h0);
    check("arst_sync",   32'(bus.sync_dout), 32'h0);
    bus.wr_en_a = 1'b0; bus.sync_din = 2'b00;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.addr_a = 2'(a);
      bus.addr_b = 2'(3 - a);
      tick();
      check($sformatf("post_rst_a%0d", a), bus.dout_a, 32'h0);
      check($sformatf("post_rst_b%0d", 3 - a), bus.dout_b, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dc_ram_sync2ff.md
Name: dc_ram_sync2ff

Overview:
- Single-clock debug mailbox primitive: a small true dual-port RAM plus a bank of two-flop synchronizers.
- Port A is the debug-host side and port B is the CPU/controller side.
- The host's request strobe enters the controller domain through the synchronizer bank; the controller's acknowledge leaves through another bit of the same bank.
- Used as the storage and handshake core of the debug controller (command/address/data/result words at addresses 0..3).

Parameters:
- addr_bits, 2, RAM address width; depth = 2**addr_bits words.
- data_bits, 32, RAM word width.
- sync_width, 2, number of independent single-bit synchronizer channels.

Ports:
- clk, in, 1, sole clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- addr_a, in, addr_bits, port A address.
- din_a, in, data_bits, port A write data.
- wr_en_a, in, 1, port A write enable.
- dout_a, out, data_bits, port A registered read data.
- addr_b, in, addr_bits, port B address.
- din_b, in, data_bits, port B write data.
- wr_en_b, in, 1, port B write enable.
- dout_b, out, data_bits, port B registered read data.
- sync_din, in, sync_width, asynchronous single-bit inputs (bit 0 = req, bit 1 = ack by convention).
- sync_dout, out, sync_width, synchronized outputs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - every RAM word cleared to 0;
  - dout_a and dout_b = 0;
  - both synchronizer stages of every channel = 0.
  - All of these are held while rst_n is low.
- Reset release is synchronous in effect: the first active edge is the first rising clk after rst_n rises.
- RAM read, each port independently:
  - every cycle dout_x <= mem[addr_x], one-cycle latency;
  - reads are unconditional (no read enable).
- RAM write: when wr_en_x = 1, mem[addr_x] <= din_x at the clock edge.
- Read-during-write on the same port: dout shows the old word (read-first). The new value is visible one cycle later.
- Cross-port, same address:
  - a write on one port and a read on the other in the same cycle returns the old word;
  - a read on the following cycle returns the new word.
- Write collision (both ports write the same address in the same cycle): port A wins; port B's data is discarded.
- Writes to different addresses in the same cycle both complete.
- Address wrap: addresses are exact-width; no out-of-range case exists.
- Synchronizer, per channel i:
  - stage1[i] <= sync_din[i];
  - stage2[i] <= stage1[i];
  - sync_dout[i] = stage2[i].
  - Latency is exactly 2 rising edges from a stable input change to the output change.
  - Pulses shorter than one clock may be lost; no pulse stretching is performed.
- No combinational path from any input to any output; all outputs are registered.
- Mid-operation reset: any write in progress is discarded, and all memory, outputs and synchronizer stages go to 0 immediately.

Test Plan:
- Reset check: assert rst_n=0 mid-run with nonzero memory → dout_a=dout_b=0, sync_dout=0 immediately. After release, read all 4 addresses on both ports → 0.
- Port A write / port B read:
  - write addr_a=2, din_a=0xDEADBEEF;
  - next cycle addr_b=2 → dout_b=0xDEADBEEF one cycle later.
  - Repeat B→A with addr 3, value 0x12345678.
- Read-first check:
  - mem[1]=0x11111111;
  - in the same cycle, port A writes addr 1 = 0x22222222 while port B reads addr 1 → dout_b=0x11111111;
  - next read of addr 1 → 0x22222222.
- Collision check: both ports write addr 0 in the same cycle (A=0xAAAA0000, B=0xBBBB0000) → subsequent read of addr 0 = 0xAAAA0000.
- Synchronizer latency:
  - raise sync_din[0] just after edge N → sync_dout[0] is 0 at N+1 and 1 after edge N+2;
  - drop it → returns to 0 two edges later;
  - channel 1 stays independent.
- Request/ack loop: drive sync_din[0] high, wait for sync_dout[0], drive sync_din[1] high → sync_dout[1] rises exactly 2 edges later. Then drop both inputs → both outputs clear with the same 2-edge latency.
